// File: rtl/preio_pkg.sv
// Shared constants and helpers for the preio_bank pad-lane IO block.
// Imported by the bank top and the per-lane filter.
package preio_pkg;

   localparam logic MODE_SDR = 1'b0;
   localparam logic MODE_DDR = 1'b1;

   localparam int SYNC_MIN = 2;
   localparam int SYNC_MAX = 4;

   function automatic int cnt_width(input int flen);
      int w;
      w = $clog2(flen + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/preio_filter.sv
// One pad lane: input synchroniser, glitch-rejecting level filter and
// registered rise/fall event pulses, all on the active edge.
module preio_filter
   import preio_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int FILTER_LEN  = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic ce,
   input  logic pad,
   output logic filt,
   output logic rise,
   output logic fall
);

   localparam int SS = (SYNC_STAGES < SYNC_MIN) ? SYNC_MIN :
                       (SYNC_STAGES > SYNC_MAX) ? SYNC_MAX : SYNC_STAGES;
   localparam int CW = cnt_width(FILTER_LEN);

   logic [SS-1:0] sync_q;
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;
   logic          filt_d;
   logic          s;

   assign s = sync_q[SS-1];

   // cnt counts consecutive cycles that s disagrees with the filtered level
   always_comb begin
      cnt_d  = '0;
      filt_d = filt;
      if (FILTER_LEN == 0) begin
         filt_d = s;
      end else if (s != filt) begin
         if (cnt_q == CW'(FILTER_LEN - 1)) filt_d = s;
         else cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         cnt_q  <= '0;
         filt   <= 1'b0;
         rise   <= 1'b0;
         fall   <= 1'b0;
      end else if (ce) begin
         sync_q <= {sync_q[SS-2:0], pad};
         cnt_q  <= cnt_d;
         filt   <= filt_d;
         rise   <= filt_d & ~filt;
         fall   <= ~filt_d & filt;
      end else begin
         rise <= 1'b0;
         fall <= 1'b0;
      end
   end

endmodule

// File: rtl/preio_bank.sv
// Multi-lane pad IO bank: SDR/DDR output registers, output enable,
// DDR input capture with hold, and per-lane filtered input events.
module preio_bank
   import preio_pkg::*;
#(
   parameter int   WIDTH       = 8,
   parameter logic NEG_TRIGGER = 1'b0,
   parameter int   SYNC_STAGES = 2,
   parameter int   FILTER_LEN  = 4
) (
   input  logic             CLK,
   input  logic             RESETN,
   input  logic             CLOCKENABLE,
   input  logic             LATCHINPUTVALUE,
   input  logic [WIDTH-1:0] OUTPUTENABLE,
   input  logic [WIDTH-1:0] DDR_MODE,
   input  logic [WIDTH-1:0] DOUT0,
   input  logic [WIDTH-1:0] DOUT1,
   output logic [WIDTH-1:0] DIN0,
   output logic [WIDTH-1:0] DIN1,
   input  logic [WIDTH-1:0] PADIN,
   output logic [WIDTH-1:0] PADOUT,
   output logic [WIDTH-1:0] PADOEN,
   output logic [WIDTH-1:0] DIN_FILT,
   output logic [WIDTH-1:0] RISE_EV,
   output logic [WIDTH-1:0] FALL_EV
);

   // clk_a rises on the active edge whichever CLK polarity is selected
   logic clk_a;
   assign clk_a = CLK ^ NEG_TRIGGER;

   logic [WIDTH-1:0] q0;
   logic [WIDTH-1:0] q1;
   logic [WIDTH-1:0] q1_b;
   logic [WIDTH-1:0] oe_q;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic [WIDTH-1:0] rise_q;
   logic [WIDTH-1:0] fall_q;

   always_ff @(posedge clk_a or negedge RESETN) begin
      if (!RESETN) begin
         q0   <= '0;
         q1   <= '0;
         oe_q <= '0;
         in_a <= '0;
         DIN0 <= '0;
         DIN1 <= '0;
      end else if (CLOCKENABLE) begin
         q0   <= DOUT0;
         q1   <= DOUT1;
         oe_q <= OUTPUTENABLE;
         if (!LATCHINPUTVALUE) begin
            in_a <= PADIN;
            DIN0 <= in_a;
            DIN1 <= in_b;
         end
      end
   end

   always_ff @(negedge clk_a or negedge RESETN) begin
      if (!RESETN) begin
         q1_b <= '0;
         in_b <= '0;
      end else if (CLOCKENABLE) begin
         q1_b <= q1;
         if (!LATCHINPUTVALUE) in_b <= PADIN;
      end
   end

   assign PADOEN  = oe_q;
   assign RISE_EV = rise_q & {WIDTH{CLOCKENABLE}};
   assign FALL_EV = fall_q & {WIDTH{CLOCKENABLE}};

   for (genvar i = 0; i < WIDTH; i++) begin : g_lane
      assign PADOUT[i] = (DDR_MODE[i] == MODE_DDR && !clk_a) ? q1_b[i] : q0[i];

      preio_filter #(
         .SYNC_STAGES (SYNC_STAGES),
         .FILTER_LEN  (FILTER_LEN)
      ) u_filt (
         .clk   (clk_a),
         .rst_n (RESETN),
         .ce    (CLOCKENABLE),
         .pad   (PADIN[i]),
         .filt  (DIN_FILT[i]),
         .rise  (rise_q[i]),
         .fall  (fall_q[i])
      );
   end

endmodule

// File: tb/tb_preio_bank.sv
// Directed bench for preio_bank: SDR/DDR output, DDR capture, glitch
// filter, clock-enable freeze and asynchronous reset.
module tb_preio_bank;

   localparam int W = 8;

   logic         CLK    = 1'b0;
   logic         RESETN = 1'b1;
   logic         ce     = 1'b1;
   logic         liv    = 1'b0;
   logic [W-1:0] oe     = '0;
   logic [W-1:0] ddr    = '0;
   logic [W-1:0] d0     = '0;
   logic [W-1:0] d1     = '0;
   logic [W-1:0] pin    = '0;
   logic [W-1:0] seen;

   logic [W-1:0] din0, din1, padout, padoen, filt, rise, fall;
   logic [W-1:0] n_din0, n_din1, n_padout, n_padoen, n_filt, n_rise, n_fall;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 CLK = ~CLK;

   preio_bank #(.WIDTH(W)) dut (
      .CLK             (CLK),
      .RESETN          (RESETN),
      .CLOCKENABLE     (ce),
      .LATCHINPUTVALUE (liv),
      .OUTPUTENABLE    (oe),
      .DDR_MODE        (ddr),
      .DOUT0           (d0),
      .DOUT1           (d1),
      .DIN0            (din0),
      .DIN1            (din1),
      .PADIN           (pin),
      .PADOUT          (padout),
      .PADOEN          (padoen),
      .DIN_FILT        (filt),
      .RISE_EV         (rise),
      .FALL_EV         (fall)
   );

   preio_bank #(.WIDTH(W), .NEG_TRIGGER(1'b1)) dut_n (
      .CLK             (CLK),
      .RESETN          (RESETN),
      .CLOCKENABLE     (ce),
      .LATCHINPUTVALUE (liv),
      .OUTPUTENABLE    (oe),
      .DDR_MODE        (ddr),
      .DOUT0           (d0),
      .DOUT1           (d1),
      .DIN0            (n_din0),
      .DIN1            (n_din1),
      .PADIN           (pin),
      .PADOUT          (n_padout),
      .PADOEN          (n_padoen),
      .DIN_FILT        (n_filt),
      .RISE_EV         (n_rise),
      .FALL_EV         (n_fall)
   );

   task automatic chk(input string tag, input logic [W-1:0] obs,
                      input logic [W-1:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step_a();
      @(posedge CLK);
      #1;
   endtask

   task automatic step_b();
      @(negedge CLK);
      #1;
   endtask

   initial begin
      // reset state
      #1 RESETN = 1'b0;
      #1;
      chk("rst_padoen", padoen, 8'h00);
      chk("rst_padout", padout, 8'h00);
      chk("rst_din0", din0, 8'h00);
      chk("rst_din1", din1, 8'h00);
      chk("rst_filt", filt, 8'h00);
      #1 RESETN = 1'b1;

      // SDR output
      oe = 8'hFF; ddr = 8'h00; d0 = 8'hFF;
      step_a();
      chk("sdr_oe", padoen, 8'hFF);
      chk("sdr_out1", padout, 8'hFF);
      d0 = 8'h00;
      step_b();
      chk("sdr_out1_low", padout, 8'hFF);
      step_a();
      chk("sdr_out0", padout, 8'h00);
      d0 = 8'hFF;
      step_a();
      chk("sdr_out1b", padout, 8'hFF);

      // DDR output, both trigger polarities
      ddr = 8'hFF; d0 = 8'hFF; d1 = 8'h00;
      step_a();
      chk("ddr_hi", padout, 8'hFF);
      step_b();
      chk("ddr_lo", padout, 8'h00);
      chk("ddrn_lo", n_padout, 8'hFF);
      step_a();
      chk("ddr_hi2", padout, 8'hFF);
      chk("ddrn_hi", n_padout, 8'h00);

      // mixed SDR/DDR lanes
      ddr = 8'h0F; d0 = 8'hA5; d1 = 8'h3C;
      step_a();
      chk("mix_hi", padout, 8'hA5);
      step_b();
      chk("mix_lo", padout, 8'hAC);

      // DDR input capture and hold
      pin = 8'hC3;
      step_a();
      chk("cap_lat", din0, 8'h00);
      pin = 8'h96;
      step_b();
      pin = 8'h00;
      step_a();
      chk("cap_din0", din0, 8'hC3);
      chk("cap_din1", din1, 8'h96);
      liv = 1'b1; pin = 8'h3C;
      step_a();
      step_a();
      chk("hold_din0", din0, 8'hC3);
      chk("hold_din1", din1, 8'h96);
      liv = 1'b0; pin = 8'h00;
      repeat (10) step_a();
      chk("short_rej", filt, 8'h00);

      // 3-cycle glitch rejected
      pin = 8'h01;
      repeat (3) step_a();
      pin = 8'h00;
      seen = '0;
      for (int i = 0; i < 8; i++) begin
         step_a();
         seen |= rise;
      end
      chk("g3_rise", seen, 8'h00);
      chk("g3_filt", filt, 8'h00);

      // 4-cycle pulse accepted
      pin = 8'h01;
      repeat (4) step_a();
      pin = 8'h00;
      step_a();
      chk("g4_a5_filt", filt, 8'h00);
      chk("g4_a5_rise", rise, 8'h00);
      step_a();
      chk("g4_a6_filt", filt, 8'h01);
      chk("g4_a6_rise", rise, 8'h01);
      step_a();
      chk("g4_a7_rise", rise, 8'h00);
      repeat (2) step_a();
      chk("g4_a9_filt", filt, 8'h01);
      chk("g4_a9_fall", fall, 8'h00);
      step_a();
      chk("g4_a10_filt", filt, 8'h00);
      chk("g4_a10_fall", fall, 8'h01);
      step_a();
      chk("g4_a11_fall", fall, 8'h00);

      // clock-enable freeze mid-transfer with a filter count in flight
      ddr = 8'hFF; d0 = 8'hFF; d1 = 8'h00; pin = 8'h02;
      repeat (3) step_a();
      chk("ce_pre_din0", din0, 8'h02);
      ce = 1'b0; d0 = 8'h00; d1 = 8'hFF;
      for (int i = 0; i < 5; i++) begin
         step_b();
         chk("ce_lo", padout, 8'h00);
         step_a();
         chk("ce_hi", padout, 8'hFF);
         chk("ce_filt", filt, 8'h00);
         chk("ce_rise", rise, 8'h00);
      end
      ce = 1'b1;
      step_a();
      chk("res_hi", padout, 8'h00);
      step_b();
      chk("res_lo", padout, 8'hFF);
      step_a();
      chk("res_r2_filt", filt, 8'h00);
      step_a();
      chk("res_r3_filt", filt, 8'h02);
      chk("res_r3_rise", rise, 8'h02);
      chk("res_din0", din0, 8'h02);

      // asynchronous reset mid-operation
      oe = 8'hFF; ddr = 8'h00; d0 = 8'hFF; pin = 8'hFF;
      repeat (10) step_a();
      chk("pre_filt", filt, 8'hFF);
      chk("pre_din0", din0, 8'hFF);
      chk("pre_din1", din1, 8'hFF);
      #2 RESETN = 1'b0;
      #1;
      chk("ar_padoen", padoen, 8'h00);
      chk("ar_padout", padout, 8'h00);
      chk("ar_din0", din0, 8'h00);
      chk("ar_din1", din1, 8'h00);
      chk("ar_filt", filt, 8'h00);
      #3 RESETN = 1'b1;

      // pad held high through reset
      repeat (5) step_a();
      chk("post_a5_filt", filt, 8'h00);
      step_a();
      chk("post_a6_filt", filt, 8'hFF);
      chk("post_a6_rise", rise, 8'hFF);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/preio_bank.md
Name: preio_bank

Overview:
- Parametrised multi-lane successor to the single-pad PREIO register cell.
- WIDTH independent pad lanes, each with registered SDR/DDR output, a registered output enable, DDR input capture and an input-hold latch.
- Adds per-lane behaviour the single cell lacks: runtime SDR/DDR select, an input synchroniser with glitch filter, and rise/fall event pulses.
- Sits between fabric logic and the pad ring; one instance per IO bank.

Parameters:
- WIDTH, 8, number of pad lanes.
- NEG_TRIGGER, 1'b0, 1 = active edge is falling CLK for all flops; the opposite edge swaps accordingly.
- SYNC_STAGES, 2, synchroniser depth on the filtered input path; legal range 2..4.
- FILTER_LEN, 4, consecutive mismatching cycles needed to accept a filtered level change; 0 = bypass.

Ports:
- CLK  in  1  sole clock.
- RESETN  in  1  asynchronous, active-low reset.
- CLOCKENABLE  in  1  global enable; low = every register holds.
- LATCHINPUTVALUE  in  1  high = DIN0/DIN1 capture registers hold.
- OUTPUTENABLE  in  WIDTH  per-lane drive request.
- DDR_MODE  in  WIDTH  per lane: 1 = DDR, 0 = SDR.
- DOUT0  in  WIDTH  data for the active-edge half-cycle.
- DOUT1  in  WIDTH  data for the opposite-edge half-cycle; ignored in SDR.
- DIN0  out  WIDTH  pad value captured at the active edge.
- DIN1  out  WIDTH  pad value captured at the opposite edge, retimed to the active edge.
- PADIN  in  WIDTH  pad input.
- PADOUT  out  WIDTH  pad output data.
- PADOEN  out  WIDTH  pad drive enable; 1 = drive.
- DIN_FILT  out  WIDTH  synchronised, glitch-filtered pad level.
- RISE_EV  out  WIDTH  one-cycle pulse on a filtered 0->1 change.
- FALL_EV  out  WIDTH  one-cycle pulse on a filtered 1->0 change.

Behaviour:
- Reset (RESETN low, asynchronous, effective immediately even mid-cycle): every register clears to 0.
  - PADOEN=0, PADOUT=0, DIN0/DIN1=0, DIN_FILT=0, events=0, filter counters=0.
- Edges: A = posedge CLK when NEG_TRIGGER=0, otherwise negedge; B = the other edge.
- CLOCKENABLE=0: all registers hold (output, input, sync, filter). RISE_EV/FALL_EV are forced 0.
- Output path, per lane:
  - At A: q0<=DOUT0, q1<=DOUT1, oe_q<=OUTPUTENABLE.
  - At B: q1_b<=q1.
  - PADOEN = oe_q.
  - SDR: PADOUT = q0.
  - DDR: PADOUT = q0 while CLK is in the phase following A, q1_b in the phase following B.
  - Latency: DOUT0 sampled at A(k) is on the pad from A(k); DOUT1 sampled at A(k) is on the pad from B(k).
  - DDR_MODE changes take effect on the next half-cycle with no extra pipeline stage.
- Input capture path, per lane, with LATCHINPUTVALUE=0:
  - At A: in_a<=PADIN.
  - At B: in_b<=PADIN.
  - At A: DIN0<=in_a, DIN1<=in_b.
  - Both outputs therefore change only at A; latency is 2 A-edges for DIN0.
- LATCHINPUTVALUE=1: in_a, in_b, DIN0 and DIN1 hold. The filter path is unaffected.
- Filter path, per lane, active-edge clocked:
  - PADIN passes through SYNC_STAGES flops to give s.
  - If s != DIN_FILT: when cnt == FILTER_LEN-1, then DIN_FILT<=s and cnt<=0; otherwise cnt<=cnt+1.
  - If s == DIN_FILT: cnt<=0.
  - A mismatch shorter than FILTER_LEN cycles is rejected; one of exactly FILTER_LEN cycles is accepted.
  - FILTER_LEN=0: DIN_FILT<=s every edge.
- Events: RISE_EV/FALL_EV are registered and assert in the same cycle DIN_FILT changes, for exactly one cycle.
- Post-reset: a pad held high through reset yields DIN_FILT=1 and a RISE_EV at A-edge SYNC_STAGES+FILTER_LEN after release.
- Widths: cnt is $clog2(FILTER_LEN+1) bits, minimum 1, and never exceeds FILTER_LEN-1.

Decomposition:
- Package preio_pkg holds:
  - Mode constants MODE_SDR=1'b0, MODE_DDR=1'b1.
  - A function returning the counter width for a given FILTER_LEN.
  - Legal range localparams for SYNC_STAGES.
- Sub-module preio_filter: a single lane containing the synchroniser, glitch counter and edge-event registers.
  - Instantiated WIDTH times by a generate loop.
  - Output and capture registers stay in preio_bank.

Test Plan:
- SDR output: DDR_MODE=0, OUTPUTENABLE=1, DOUT0 sequence 1,0,1 over 3 A-edges -> PADOUT tracks it one A-edge later, full cycles; PADOEN=1 from the first A.
- DDR output: DDR_MODE=1, DOUT0=1, DOUT1=0 held -> PADOUT toggles 1/0 every half-cycle. Repeat with NEG_TRIGGER=1 -> phases swap.
- DDR input: PADIN driven 1 before A, 0 before B -> DIN0=1, DIN1=0 after the second A. Assert LATCHINPUTVALUE then flip PADIN -> DIN0/DIN1 unchanged.
- Glitch filter (SYNC_STAGES=2, FILTER_LEN=4):
  - PADIN high pulse of 3 cycles -> DIN_FILT stays 0, no RISE_EV.
  - 4-cycle pulse -> DIN_FILT=1 and RISE_EV one cycle after A-edge 6 from the pulse start; FALL_EV 6 edges after the fall.
- CLOCKENABLE=0 for 5 cycles mid-DDR transfer -> PADOUT, DIN and counters frozen, events 0. Resume continues from the held state.
- RESETN low mid-operation with all lanes driving -> PADOEN, PADOUT, DIN0, DIN1, DIN_FILT fall to 0 immediately, without waiting for an edge.
